// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES-128 key expansion, one round per cycle; KEY_SCHED_CACHE_EN skips re-expanding the resident key
module key_schedule_ctrl #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  localparam logic [1:0] IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // rcon bytes stored little-endian so round r sits at bits [8r+7:8r]
  localparam logic [79:0] RCON = 80'h361b8040201008040201;

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [127:0] rk [0:NROUNDS];
  logic [127:0] cur;
  logic [31:0]  t, w0, w1, w2, w3;
  logic         hit;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  assign key_ready = state == IDLE;
  assign busy      = state == EXPAND;
  assign done      = state == DONE;
  assign cur       = rk[cnt];

`ifdef KEY_SCHED_CACHE_EN
  assign hit = keys_valid && key_in == rk[0];
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    t  = {sbox(cur[23:16]) ^ RCON[{cnt, 3'b111} -: 8], sbox(cur[15:8]), sbox(cur[7:0]), sbox(cur[31:24])};
    w0 = cur[127:96] ^ t;
    w1 = cur[95:64] ^ w0;
    w2 = cur[63:32] ^ w1;
    w3 = cur[31:0] ^ w2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      keys_valid <= 1'b0;
      rd_key     <= '0;
      for (int i = 0; i <= NROUNDS; i++) rk[i] <= '0;
    end else begin
      rd_key <= rd_round <= 4'(NROUNDS) ? rk[rd_round] : '0;
      if (state == IDLE && key_valid) begin
        if (hit) state <= DONE;
        else begin
          rk[0]      <= key_in;
          cnt        <= '0;
          keys_valid <= 1'b0;
          state      <= EXPAND;
        end
      end else if (state == EXPAND) begin
        rk[cnt + 4'd1] <= {w0, w1, w2, w3};
        cnt            <= cnt + 4'd1;
        if (cnt == 4'(NROUNDS - 1)) state <= DONE;
      end else if (state == DONE) begin
        keys_valid <= 1'b1;
        state      <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: directed checks of key_schedule_ctrl against FIPS-197 and all-zero key schedules
module tb_key_schedule_ctrl;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_K5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst_n, key_valid, key_ready, busy, done, keys_valid;
  logic [127:0] key_in, rd_key;
  logic [3:0]   rd_round;
  int           checks = 0, failures = 0, n;
  logic         done_seen;

  key_schedule_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid), .rd_round(rd_round), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int cyc);
    cyc = 0;
    for (int i = start; i <= start + 30; i++) begin
      if (done) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [3:0] r, input logic [127:0] exp, input string tag);
    rd_round = r;
    @(negedge clk);
    check(tag, rd_key, exp);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rd_round = '0;
    repeat (2) @(negedge clk);
    check("rst_key_ready", key_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_keys_valid", keys_valid, 0);
    check("rst_rd_key", rd_key, '0);
    rd_round = 4'd15;
    @(negedge clk);
    check("rst_rd_key15", rd_key, '0);
    rst_n = 1'b1;
    @(negedge clk);

    load(FIPS_K0);
    check("fips_busy", busy, 1);
    check("fips_kv_low", keys_valid, 0);
    wait_done(1, n);
    check("fips_latency", 128'(n), 11);
    rd_round = 4'd10;
    @(negedge clk);
    check("fips_rd_in_done", rd_key, FIPS_K10);
    check("fips_kv_high", keys_valid, 1);
    check("fips_ready", key_ready, 1);
    check("fips_done_pulse", done, 0);
    rd(4'd0, FIPS_K0, "rd_rk0");
    rd(4'd1, FIPS_K1, "rd_rk1");
    rd(4'd2, FIPS_K2, "rd_rk2");
    rd(4'd5, FIPS_K5, "rd_rk5");
    rd(4'd10, FIPS_K10, "rd_rk10");
    rd(4'd11, '0, "rd_11");
    rd(4'd15, '0, "rd_15");

    load(FIPS_K0);
`ifdef KEY_SCHED_CACHE_EN
    check("cache_kv_held", keys_valid, 1);
    wait_done(1, n);
    check("cache_latency", 128'(n), 1);
`else
    check("reload_kv_low", keys_valid, 0);
    wait_done(1, n);
    check("reload_latency", 128'(n), 11);
`endif
    @(negedge clk);
    check("reload_kv_high", keys_valid, 1);
    rd(4'd10, FIPS_K10, "reload_rk10");

    key_valid = 1'b1;
    key_in    = '0;
    @(negedge clk);
    key_in = FIPS_K0;
    check("hs_busy", busy, 1);
    check("hs_kv_low", keys_valid, 0);
    wait_done(1, n);
    check("hs_first_latency", 128'(n), 11);
    rd_round = 4'd1;
    @(negedge clk);
    check("hs_zero_rk1", rd_key, ZERO_K1);
    check("hs_ready", key_ready, 1);
    check("hs_kv_high", keys_valid, 1);
    @(negedge clk);
    check("hs_second_accept", busy, 1);
    check("hs_kv_drop", keys_valid, 0);
    key_valid = 1'b0;
    wait_done(1, n);
    check("hs_second_latency", 128'(n), 11);
    @(negedge clk);
    rd(4'd0, FIPS_K0, "hs_rk0");
    rd(4'd10, FIPS_K10, "hs_rk10");

    load('0);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", key_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_kv", keys_valid, 0);
    check("mid_rst_rd_key", rd_key, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("mid_rst_no_done", done_seen, 0);
    check("mid_rst_kv_after", keys_valid, 0);
    rd(4'd1, '0, "mid_rst_rk1_cleared");
    load(FIPS_K0);
    wait_done(1, n);
    check("post_rst_latency", 128'(n), 11);
    @(negedge clk);
    check("post_rst_kv", keys_valid, 1);
    rd(4'd1, FIPS_K1, "post_rst_rk1");
    rd(4'd10, FIPS_K10, "post_rst_rk10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
